mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Round-robin arbiter and access sequencer that shares the single-port data `memory` between `N_REQ` requesters, such as fetch, load/store and a debug loader. It accepts held-request transactions and drives `memory`'s `write`/`read`/`address`/`mem_data_in` for exactly one cycle per access. It captures `mem_data_out` into a per-port read-data register and returns a one-cycle acknowledge. It sits between the CPU-side ports and the `memory` instance.

## Interface
- `N_REQ`, default 2: number of requester ports, legal range 2..8.
- Widths `A_BITS`, `D_BITS` and depth `MEMSIZE` come from `macros.vh` and are not parameters.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `req`, in, `N_REQ`: per-port request; held high with its command stable until the matching `ack`.
- `we`, in, `N_REQ`: per-port 1 = write, 0 = read.
- `addr`, in, `N_REQ*A_BITS`: per-port address; port i is in slice [i*A_BITS +: A_BITS].
- `wdata`, in, `N_REQ*D_BITS`: per-port write data.
- `ack`, out, `N_REQ`: one-cycle completion pulse.
- `err`, out, `N_REQ`: pulses with `ack` when the address is ≥ `MEMSIZE`.
- `rdata`, out, `N_REQ*D_BITS`: per-port read data, held until that port's next successful read.
- `mem_write`, out, 1: connects to `memory.write`.
- `mem_read`, out, 1: connects to `memory.read`.
- `mem_address`, out, `A_BITS`: connects to `memory.address`.
- `mem_data_in`, out, `D_BITS`: connects to `memory.mem_data_in`.
- `mem_data_out`, in, `D_BITS`: connects to `memory.mem_data_out`.

## Operation
- **FSM states:** IDLE, BUSY, RESP.
- **IDLE:**
  - If any `req` bit is set, pick the winner by round-robin. The search starts at `last+1` mod `N_REQ`.
  - Latch `owner`, `we`, `addr` and `wdata` into command registers, set `last` to `owner`, then go to BUSY.
  - If no `req` bit is set, stay in IDLE.
- **BUSY (exactly one cycle):**
  - In range, write: `mem_write`=1, `mem_read`=0, `mem_address` and `mem_data_in` from the latched command.
  - In range, read: `mem_write`=0, `mem_read`=1. At the closing edge, `rdata[owner]` takes `mem_data_out`.
  - Address ≥ `MEMSIZE`: both strobes stay 0, `rdata` is unchanged, and `err[owner]` is set for RESP.
  - Next state is always RESP.
- **RESP (one cycle):**
  - `ack[owner]`=1; `err[owner]`=1 if the access was out of range.
  - All `req` inputs are ignored in this cycle, because the owner still presents its old command.
  - Next state is IDLE.
- **Strobe rules:**
  - `mem_write` and `mem_read` are never both 1.
  - Both are 0 outside BUSY.
  - `mem_address` and `mem_data_in` hold their last latched values outside BUSY; they are 0 after reset.
- **Fairness:**
  - A requester that holds `req` waits at most `N_REQ-1` other accesses before it is granted.
  - A port whose `req` drops before grant is simply not served; no error is raised.
- **Reset (async, also mid-operation):**
  - State goes to IDLE; `ack`, `err`, `mem_write` and `mem_read` go to 0 immediately; `rdata`, `mem_address` and `mem_data_in` clear to 0.
  - `last` is set to `N_REQ-1`, so port 0 wins the first conflict.
  - An access interrupted by reset is dropped with no `ack`. The requester keeps `req` high and is re-arbitrated after reset is released.

## Timing
- `req` first seen high in IDLE at edge k:
  - BUSY in cycle k+1;
  - `ack` and `rdata` valid in cycle k+2;
  - earliest next grant decision at edge k+3.
- Throughput: one access per 3 cycles, no idle bubbles while any request is pending.
- Back-to-back on the same port: the requester changes its command during the `ack` cycle. The new command is sampled in IDLE, so the next `ack` is 3 cycles later.
- Write-then-read to the same address, from any ports, always returns the written data.

## Structure
- Package `mem_arb_pkg` holds:
  - the `state_t` enum (IDLE, BUSY, RESP);
  - `PTR_BITS` = `$clog2(N_REQ)`, for the `owner` and `last` registers;
  - a range-check function `in_range(addr)` that compares against `` `MEMSIZE ``.
- Sub-module `rr_picker` is purely combinational. It takes `req` and `last` and outputs `valid` and a `grant` index. It is reused by any later arbiters.
- FSM, command registers and the `rdata` bank stay in `mem_arbiter`.

## Test plan
- **Single write then read:** port0 writes 0xA5 to address 5, then reads address 5.
  - `ack[0]` arrives 2 cycles after each `req`.
  - `mem_write` is high exactly one cycle.
  - `rdata[0]`=0xA5.
- **First conflict after reset:** ports 0 and 1 both request read of address 3 in the same cycle.
  - Port0 is granted first (`ack[0]` at cycle +2).
  - Port1 `ack[1]` at cycle +5.
  - Both `rdata` values equal M[3].
- **Continuous contention, `N_REQ`=3:** all ports request continuously for 12 accesses.
  - Grant order is 0,1,2,0,1,2…
  - `ack` pulses are exactly 3 cycles apart.
  - No port waits more than 2 accesses.
- **Out-of-range read:** port1 reads address `MEMSIZE`.
  - `ack[1]` and `err[1]` pulse together.
  - `mem_read` and `mem_write` stay 0 throughout.
  - `rdata[1]` is unchanged.
- **Reset during BUSY of a port0 write:**
  - `mem_write` and `ack` drop in the same cycle as `rst`.
  - No `ack` is issued for the interrupted access.
  - After release, the held `req` is re-served with `ack` 2 cycles after the first IDLE edge.
- **Cross-port coherence:** port1 writes 0x3C to address 7 while port0 holds a read of address 7 queued behind it.
  - Port0 receives `rdata`=0x3C.

Source files
------------

// File: rtl/mem_arb_pkg.sv
//==============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and helpers for the memory arbiter slice:
//               FSM state encoding, pointer width helper and address range
//               check against the memory depth.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

// Memory geometry normally comes from macros.vh; these fallbacks apply only
// when that header has not already defined them.
`ifndef A_BITS
`define A_BITS 8
`endif
`ifndef D_BITS
`define D_BITS 8
`endif
`ifndef MEMSIZE
`define MEMSIZE 128
`endif

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Width of the owner/last pointers for n requesters ($clog2(n), min 1).
  function automatic int ptr_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // True when the address lies inside the physical memory.
  function automatic logic in_range(input logic [`A_BITS-1:0] a);
    return (32'(a) < 32'(`MEMSIZE));
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
//==============================================================================
// Module      : rr_picker
// Description : Combinational round-robin picker. Searches req starting at
//               last+1 (mod N) and returns the first set index.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_picker
  import mem_arb_pkg::*;
#(
  parameter  int N        = 2,
  localparam int PTR_BITS = ptr_bits(N)
) (
  input  logic [N-1:0]        req,
  input  logic [PTR_BITS-1:0] last,
  output logic                valid,
  output logic [PTR_BITS-1:0] grant
);

  // Walk the ring one step at a time from last; the first hit wins.
  always_comb begin
    logic [PTR_BITS-1:0] idx;
    valid = 1'b0;
    grant = '0;
    idx   = last;
    for (int i = 0; i < N; i++) begin
      idx = (idx == PTR_BITS'(N - 1)) ? '0 : idx + 1'b1;
      if (!valid && req[idx]) begin
        valid = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
//==============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter and access sequencer sharing a single-port
//               memory between N_REQ requesters. Each access takes three
//               cycles: grant (IDLE), one memory strobe cycle (BUSY) and a
//               one-cycle acknowledge (RESP).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int N_REQ    = 2,
  localparam int PTR_BITS = ptr_bits(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          we,
  input  logic [N_REQ*`A_BITS-1:0]  addr,
  input  logic [N_REQ*`D_BITS-1:0]  wdata,
  output logic [N_REQ-1:0]          ack,
  output logic [N_REQ-1:0]          err,
  output logic [N_REQ*`D_BITS-1:0]  rdata,
  output logic                      mem_write,
  output logic                      mem_read,
  output logic [`A_BITS-1:0]        mem_address,
  output logic [`D_BITS-1:0]        mem_data_in,
  input  logic [`D_BITS-1:0]        mem_data_out
);

  state_t              state;
  state_t              state_nx;
  logic [PTR_BITS-1:0] owner;
  logic [PTR_BITS-1:0] last;
  logic [PTR_BITS-1:0] grant;
  logic                grant_valid;

  logic                cmd_we;
  logic                cmd_oor;
  logic [`A_BITS-1:0]  cmd_addr;
  logic [`D_BITS-1:0]  cmd_wdata;

  logic                sel_we;
  logic [`A_BITS-1:0]  sel_addr;
  logic [`D_BITS-1:0]  sel_wdata;

  logic                take_cmd;
  logic                capture;

  rr_picker #(.N(N_REQ)) u_picker (
    .req   (req),
    .last  (last),
    .valid (grant_valid),
    .grant (grant)
  );

  // Route the winning port's command to the command registers.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant == PTR_BITS'(i)) begin
        sel_we    = we[i];
        sel_addr  = addr[i*`A_BITS +: `A_BITS];
        sel_wdata = wdata[i*`D_BITS +: `D_BITS];
      end
    end
  end

  // Requests are only looked at in IDLE; RESP ignores the owner's stale req.
  assign take_cmd = (state == IDLE) && grant_valid;
  assign capture  = (state == BUSY) && !cmd_we && !cmd_oor;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM next-state logic: IDLE waits for a winner, BUSY and RESP last one cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = grant_valid ? BUSY : IDLE;
      BUSY:    state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs: strobes only in BUSY and only for in-range accesses.
  always_comb begin
    mem_write = 1'b0;
    mem_read  = 1'b0;
    ack       = '0;
    err       = '0;
    if (state == BUSY && !cmd_oor) begin
      mem_write = cmd_we;
      mem_read  = !cmd_we;
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (state == RESP && owner == PTR_BITS'(i)) begin
        ack[i] = 1'b1;
        err[i] = cmd_oor;
      end
    end
  end

  // Latch the granted command; last starts at N_REQ-1 so port 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= '0;
      last      <= PTR_BITS'(N_REQ - 1);
      cmd_we    <= 1'b0;
      cmd_oor   <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (take_cmd) begin
      owner     <= grant;
      last      <= grant;
      cmd_we    <= sel_we;
      cmd_oor   <= !in_range(sel_addr);
      cmd_addr  <= sel_addr;
      cmd_wdata <= sel_wdata;
    end
  end

  // The memory bus simply mirrors the latched command between accesses.
  assign mem_address = cmd_addr;
  assign mem_data_in = cmd_wdata;

  // Per-port read-data bank, updated only by that port's successful reads.
  for (genvar g = 0; g < N_REQ; g++) begin : g_rdata
    logic [`D_BITS-1:0] rd_q;

    // Capture memory output at the close of this port's BUSY read cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                     rd_q <= '0;
      else if (capture && owner == PTR_BITS'(g))   rd_q <= mem_data_out;
    end

    assign rdata[g*`D_BITS +: `D_BITS] = rd_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//==============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with three
//               requesters and a behavioural single-port memory.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    ack;
  logic [N-1:0]    err;
  logic [N*DW-1:0] rdata;
  logic            mem_write;
  logic            mem_read;
  logic [AW-1:0]   mem_address;
  logic [DW-1:0]   mem_data_in;
  logic [DW-1:0]   mem_data_out;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int wr_cycles = 0;
  int rd_cycles = 0;
  int both_cycles = 0;
  int ack_at [N];
  logic err_at [N];
  int order [12];
  int tms [12];

  always #5 clk = ~clk;

  mem_arbiter #(.N_REQ(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .we           (we),
    .addr         (addr),
    .wdata        (wdata),
    .ack          (ack),
    .err          (err),
    .rdata        (rdata),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  // Behavioural memory: synchronous write, combinational read.
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) if (mem_write) mem[mem_address] <= mem_data_in;
  assign mem_data_out = mem[mem_address];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_write) wr_cycles <= wr_cycles + 1;
    if (mem_read)  rd_cycles <= rd_cycles + 1;
    if (mem_write && mem_read) both_cycles <= both_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[p] = w;
    addr[p*AW +: AW] = a;
    wdata[p*DW +: DW] = d;
  endtask

  function automatic logic [DW-1:0] rd(input int p);
    return rdata[p*DW +: DW];
  endfunction

  // Wait (bounded) for acks on the masked ports; each port drops req on its ack.
  task automatic serve(input logic [N-1:0] mask);
    logic [N-1:0] done;
    done = '0;
    for (int p = 0; p < N; p++) begin
      ack_at[p] = -1;
      err_at[p] = 1'b0;
    end
    for (int c = 1; c <= 20 && done != mask; c++) begin
      step();
      for (int p = 0; p < N; p++) begin
        if (mask[p] && ack[p] && !done[p]) begin
          ack_at[p] = c;
          err_at[p] = err[p];
          done[p]   = 1'b1;
          req[p]    = 1'b0;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    int w0;
    int s0;
    int k;
    int start;

    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    repeat (3) step();
    check("rst_ack", 32'(ack), 0);
    check("rst_err", 32'(err), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_mem_address", 32'(mem_address), 0);
    check("rst_mem_data_in", 32'(mem_data_in), 0);
    check("rst_strobes", 32'({mem_write, mem_read}), 0);
    rst = 1'b0;
    step();

    // Single write then read on port 0.
    w0 = wr_cycles;
    set_cmd(0, 1'b1, 8'd5, 8'hA5); req[0] = 1'b1;
    serve(3'b001);
    check("wr_ack_latency", 32'(ack_at[0]), 2);
    check("wr_err", 32'(err_at[0]), 0);
    check("wr_strobe_cycles", 32'(wr_cycles - w0), 1);
    step();
    set_cmd(0, 1'b0, 8'd5, 8'h00); req[0] = 1'b1;
    serve(3'b001);
    check("rd_ack_latency", 32'(ack_at[0]), 2);
    check("rd_data_p0", 32'(rd(0)), 32'hA5);

    // First conflict after reset: port 0 before port 1.
    step();
    set_cmd(0, 1'b1, 8'd3, 8'h77); req[0] = 1'b1;
    serve(3'b001);
    do_reset();
    set_cmd(0, 1'b0, 8'd3, 8'h00);
    set_cmd(1, 1'b0, 8'd3, 8'h00);
    req = 3'b011;
    serve(3'b011);
    check("conflict_ack0", 32'(ack_at[0]), 2);
    check("conflict_ack1", 32'(ack_at[1]), 5);
    check("conflict_rdata0", 32'(rd(0)), 32'h77);
    check("conflict_rdata1", 32'(rd(1)), 32'h77);

    // Continuous contention, back-to-back commands on every port.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      order[i] = -1;
      tms[i]   = -1;
    end
    for (int p = 0; p < N; p++) set_cmd(p, 1'b0, 8'(16 + p), 8'h00);
    req = 3'b111;
    start = cyc;
    k = 0;
    for (int c = 0; c < 80 && k < 12; c++) begin
      step();
      for (int p = 0; p < N; p++) begin
        if (ack[p] && k < 12) begin
          order[k] = p;
          tms[k]   = cyc;
          k++;
          set_cmd(p, 1'b0, 8'(16 + p + 4 * k), 8'h00);
        end
      end
    end
    req = '0;
    check("rr_first_latency", 32'(tms[0] - start), 2);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("rr_order[%0d]", i), 32'(order[i]), 32'(i % 3));
      if (i > 0) check($sformatf("rr_spacing[%0d]", i), 32'(tms[i] - tms[i-1]), 3);
    end
    step(); step();

    // Out-of-range read on port 1 leaves rdata and strobes untouched.
    set_cmd(1, 1'b0, 8'd5, 8'h00); req[1] = 1'b1;
    serve(3'b010);
    check("p1_rd_data", 32'(rd(1)), 32'hA5);
    step();
    s0 = wr_cycles + rd_cycles;
    set_cmd(1, 1'b0, 8'd128, 8'h00); req[1] = 1'b1;
    serve(3'b010);
    check("oor_ack_latency", 32'(ack_at[1]), 2);
    check("oor_err", 32'(err_at[1]), 1);
    check("oor_strobes", 32'(wr_cycles + rd_cycles - s0), 0);
    check("oor_rdata_kept", 32'(rd(1)), 32'hA5);

    // Reset during the BUSY cycle of a port-0 write.
    step();
    set_cmd(0, 1'b1, 8'd9, 8'h11); req[0] = 1'b1;
    step();
    check("busy_mem_write", 32'(mem_write), 1);
    check("busy_mem_address", 32'(mem_address), 9);
    rst = 1'b1;
    #1;
    check("rst_drops_write", 32'(mem_write), 0);
    check("rst_drops_ack", 32'(ack), 0);
    step();
    rst = 1'b0;
    serve(3'b001);
    check("reserve_latency", 32'(ack_at[0]), 2);
    check("reserve_mem", 32'(mem[9]), 32'h11);

    // Cross-port coherence: port 1 write wins, port 0 read queued behind it.
    step();
    set_cmd(1, 1'b1, 8'd7, 8'h3C);
    set_cmd(0, 1'b0, 8'd7, 8'h00);
    req = 3'b011;
    serve(3'b011);
    check("coh_ack1", 32'(ack_at[1]), 2);
    check("coh_ack0", 32'(ack_at[0]), 5);
    check("coh_rdata0", 32'(rd(0)), 32'h3C);

    check("strobe_overlap", 32'(both_cycles), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
